// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel strobe in, sync/enable/position/event strobes out.
// The generator takes the master modport and the consumer takes the slave modport.
interface vga_timing_gen_if #(
  parameter int unsigned CW  = 12,
  parameter int unsigned FCW = 16
);
  logic           i_pix_stb;
  logic           o_hs;
  logic           o_vs;
  logic           o_de;
  logic [CW-1:0]  o_x;
  logic [CW-1:0]  o_y;
  logic           o_line_start;
  logic           o_frame_start;
  logic           o_vblank_start;
  logic [FCW-1:0] o_frame_cnt;

  modport master (
    input  i_pix_stb,
    output o_hs, o_vs, o_de, o_x, o_y,
    output o_line_start, o_frame_start, o_vblank_start, o_frame_cnt
  );

  modport slave (
    output i_pix_stb,
    input  o_hs, o_vs, o_de, o_x, o_y,
    input  o_line_start, o_frame_start, o_vblank_start, o_frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised progressive raster timing generator advancing on a pixel strobe.
// Every output is a register; levels are decoded from the next-state counters.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 12,
  parameter int unsigned FCW      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]  h_q, v_q, h_n, v_n;
  logic [FCW-1:0] fcnt_q, fcnt_n;
  logic           hs_q, vs_q, de_q;
  logic           line_q, frame_q, vblank_q;
  logic           h_wrap, v_wrap;
  logic           at_line_start;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Next raster position and frame count for this cycle
  always_comb begin
    h_n    = h_q;
    v_n    = v_q;
    fcnt_n = fcnt_q;
    if (bus.i_pix_stb) begin
      if (h_wrap) begin
        h_n = '0;
        if (v_wrap) begin
          v_n    = '0;
          fcnt_n = fcnt_q + FCW'(1);
        end else begin
          v_n = v_q + CW'(1);
        end
      end else begin
        h_n = h_q + CW'(1);
      end
    end
  end

  // A strobe that lands on h=0 can only come from a line wrap
  assign at_line_start = bus.i_pix_stb && (h_n == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q      <= '0;
      v_q      <= '0;
      fcnt_q   <= '0;
      de_q     <= 1'b1;
      hs_q     <= !H_POL;
      vs_q     <= !V_POL;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      h_q      <= h_n;
      v_q      <= v_n;
      fcnt_q   <= fcnt_n;
      de_q     <= (h_n < H_ACT_END) && (v_n < V_ACT_END);
      hs_q     <= ((h_n >= H_SYNC_BEG) && (h_n < H_SYNC_END)) ? H_POL : !H_POL;
      vs_q     <= ((v_n >= V_SYNC_BEG) && (v_n < V_SYNC_END)) ? V_POL : !V_POL;
      line_q   <= at_line_start;
      frame_q  <= at_line_start && (v_n == '0);
      vblank_q <= at_line_start && (v_n == V_ACT_END);
    end
  end

  assign bus.o_x            = h_q;
  assign bus.o_y            = v_q;
  assign bus.o_de           = de_q;
  assign bus.o_hs           = hs_q;
  assign bus.o_vs           = vs_q;
  assign bus.o_line_start   = line_q;
  assign bus.o_frame_start  = frame_q;
  assign bus.o_vblank_start = vblank_q;
  assign bus.o_frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes (default 800x525, tiny positive-polarity
// FCW=2, mid-size) checked against a linear strobe-count reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        vbs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  stb [3];
  logic  rst [3];
  obs_t  act [3];
  longint pcnt [3];
  bit    adv [3];

  int n_chk  = 0;
  int n_fail = 0;

  vga_timing_gen_if #(.CW(12), .FCW(16)) if_a ();
  vga_timing_gen_if #(.CW(12), .FCW(2))  if_b ();
  vga_timing_gen_if #(.CW(12), .FCW(16)) if_c ();

  assign if_a.i_pix_stb = stb[0];
  assign if_b.i_pix_stb = stb[1];
  assign if_c.i_pix_stb = stb[2];

  vga_timing_gen u_a (.i_clk(clk), .i_rst(rst[0]), .bus(if_a));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(12), .FCW(2)
  ) u_b (.i_clk(clk), .i_rst(rst[1]), .bus(if_b));

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(6), .H_BP(2),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CW(12), .FCW(16)
  ) u_c (.i_clk(clk), .i_rst(rst[2]), .bus(if_c));

  assign act[0] = {if_a.o_x, if_a.o_y, if_a.o_de, if_a.o_hs, if_a.o_vs,
                   if_a.o_line_start, if_a.o_frame_start, if_a.o_vblank_start, if_a.o_frame_cnt};
  assign act[1] = {if_b.o_x, if_b.o_y, if_b.o_de, if_b.o_hs, if_b.o_vs,
                   if_b.o_line_start, if_b.o_frame_start, if_b.o_vblank_start, 14'd0, if_b.o_frame_cnt};
  assign act[2] = {if_c.o_x, if_c.o_y, if_c.o_de, if_c.o_hs, if_c.o_vs,
                   if_c.o_line_start, if_c.o_frame_start, if_c.o_vblank_start, if_c.o_frame_cnt};

  // Reference: position and frame count derived from the number of strobes since reset
  function automatic obs_t model(input int m, input longint p, input bit a);
    longint ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, x, y, fr;
    bit hp, vp;
    int fcw;
    obs_t o;
    case (m)
      1:       begin ha=8;   hf=1;  hsw=2;  hb=1;  va=4;   vf=1;  vsw=2; vb=1;  hp=1; vp=1; fcw=2;  end
      2:       begin ha=40;  hf=2;  hsw=6;  hb=2;  va=30;  vf=2;  vsw=2; vb=3;  hp=0; vp=0; fcw=16; end
      default: begin ha=640; hf=16; hsw=96; hb=48; va=480; vf=10; vsw=2; vb=33; hp=0; vp=0; fcw=16; end
    endcase
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    fr = (p / (ht * vt)) % (64'd1 << fcw);
    o.x   = 12'(x);
    o.y   = 12'(y);
    o.de  = (x < ha) && (y < va);
    o.hs  = (x >= ha + hf && x < ha + hf + hsw) ? hp : !hp;
    o.vs  = (y >= va + vf && y < va + vf + vsw) ? vp : !vp;
    o.ls  = a && (x == 0);
    o.fs  = a && (x == 0) && (y == 0);
    o.vbs = a && (x == 0) && (y == va);
    o.fc  = 16'(fr);
    return o;
  endfunction

  // One clock: update the reference for every DUT, then settle before sampling
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      adv[k] = stb[k] && !rst[k];
      if (rst[k]) pcnt[k] = 0;
      else if (stb[k]) pcnt[k] = pcnt[k] + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    for (int k = 0; k < 3; k++) begin rst[k] = 1'b1; stb[k] = 1'b1; end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      e = model(k, pcnt[k], adv[k]);
      n_chk++;
      if (act[k] !== e) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got %h want %h", k, act[k], e);
      end
    end
    n_chk++;
    if (act[0].de !== 1'b1 || act[0].hs !== 1'b1 || act[0].x !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_levels got de=%b hs=%b x=%0d want de=1 hs=1 x=0", act[0].de, act[0].hs, act[0].x);
    end
    for (int k = 0; k < 3; k++) begin rst[k] = 1'b0; stb[k] = 1'b0; end
  endtask

  task automatic test_line();
    obs_t e;
    int ls_cnt = 0, hs_lo = 0;
    stb[0] = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      e = model(0, pcnt[0], adv[0]);
      n_chk++;
      if (act[0] !== e) begin
        n_fail++;
        $display("FAIL line_word i=%0d got %h want %h", i, act[0], e);
      end
      if (act[0].ls === 1'b1) begin
        ls_cnt++;
        n_chk++;
        if (act[0].x !== 12'd0 || act[0].y !== 12'd1) begin
          n_fail++;
          $display("FAIL line_start_pos got (%0d,%0d) want (0,1)", act[0].x, act[0].y);
        end
      end
      if (act[0].hs === 1'b0) hs_lo++;
    end
    stb[0] = 1'b0;
    n_chk++;
    if (ls_cnt != 1) begin n_fail++; $display("FAIL line_start_count got %0d want 1", ls_cnt); end
    n_chk++;
    if (hs_lo != 96) begin n_fail++; $display("FAIL hsync_width got %0d want 96", hs_lo); end
  endtask

  task automatic test_sparse_stb();
    obs_t e;
    int ls_cyc = 0;
    for (int i = 0; i < 3200; i++) begin
      stb[0] = ((i % 4) == 0);
      tick();
      e = model(0, pcnt[0], adv[0]);
      n_chk++;
      if (act[0] !== e) begin
        n_fail++;
        $display("FAIL sparse_word i=%0d got %h want %h", i, act[0], e);
      end
      if (act[0].ls === 1'b1) ls_cyc++;
    end
    stb[0] = 1'b0;
    n_chk++;
    if (ls_cyc != 1) begin n_fail++; $display("FAIL sparse_pulse_len got %0d want 1", ls_cyc); end
  endtask

  task automatic test_frame();
    obs_t e;
    int vs_lo = 0, vb_cnt = 0, fs_cnt = 0;
    rst[2] = 1'b1; tick(); rst[2] = 1'b0;
    stb[2] = 1'b1;
    for (int i = 0; i < 1853; i++) begin
      tick();
      e = model(2, pcnt[2], adv[2]);
      n_chk++;
      if (act[2] !== e) begin
        n_fail++;
        $display("FAIL frame_word i=%0d got %h want %h", i, act[2], e);
      end
      if (act[2].vs === 1'b0) vs_lo++;
      if (act[2].vbs === 1'b1) begin
        vb_cnt++;
        n_chk++;
        if (act[2].x !== 12'd0 || act[2].y !== 12'd30) begin
          n_fail++;
          $display("FAIL vblank_pos got (%0d,%0d) want (0,30)", act[2].x, act[2].y);
        end
      end
      if (act[2].fs === 1'b1) begin
        fs_cnt++;
        n_chk++;
        if (act[2].fc !== 16'd1 || act[2].ls !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_start_cnt got fc=%0d ls=%b want fc=1 ls=1", act[2].fc, act[2].ls);
        end
      end
    end
    stb[2] = 1'b0;
    n_chk++;
    if (vs_lo != 100) begin n_fail++; $display("FAIL vsync_width got %0d want 100", vs_lo); end
    n_chk++;
    if (vb_cnt != 1 || fs_cnt != 1) begin
      n_fail++;
      $display("FAIL frame_pulse_count got vb=%0d fs=%0d want 1 1", vb_cnt, fs_cnt);
    end
  endtask

  task automatic test_random_stb();
    obs_t e;
    for (int i = 0; i < 3000; i++) begin
      stb[2] = ($urandom_range(0, 3) != 0);
      tick();
      e = model(2, pcnt[2], adv[2]);
      n_chk++;
      if (act[2] !== e) begin
        n_fail++;
        $display("FAIL random_word i=%0d got %h want %h", i, act[2], e);
      end
    end
    stb[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t e;
    int guard = 0;
    stb[2] = 1'b1;
    while (!(act[2].x === 12'd20 && act[2].y === 12'd15) && guard < 2000) begin
      tick();
      guard++;
    end
    n_chk++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL reset_mid_reach got (%0d,%0d) want (20,15)", act[2].x, act[2].y);
    end
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    stb[2] = 1'b0;
    e = model(2, pcnt[2], adv[2]);
    n_chk++;
    if (act[2] !== e) begin
      n_fail++;
      $display("FAIL reset_mid_word got %h want %h", act[2], e);
    end
    n_chk++;
    if (act[2].x !== 12'd0 || act[2].y !== 12'd0 || act[2].de !== 1'b1 || act[2].ls !== 1'b0 ||
        act[2].fs !== 1'b0 || act[2].fc !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_fields got (%0d,%0d) de=%b ls=%b fs=%b fc=%0d want (0,0) 1 0 0 0",
               act[2].x, act[2].y, act[2].de, act[2].ls, act[2].fs, act[2].fc);
    end
  endtask

  task automatic test_tiny_wrap();
    obs_t e;
    int fs_cnt = 0, cyc = 0;
    longint last_ls = -1;
    while (fs_cnt < 5 && cyc < 4000) begin
      stb[1] = $urandom_range(0, 1);
      tick();
      cyc++;
      e = model(1, pcnt[1], adv[1]);
      n_chk++;
      if (act[1] !== e) begin
        n_fail++;
        $display("FAIL tiny_word c=%0d got %h want %h", cyc, act[1], e);
      end
      if (adv[1] && act[1].x === 12'd9) begin
        n_chk++;
        if (act[1].hs !== 1'b1) begin n_fail++; $display("FAIL tiny_hsync_pol got %b want 1", act[1].hs); end
      end
      if (act[1].ls === 1'b1) begin
        if (last_ls >= 0) begin
          n_chk++;
          if (pcnt[1] - last_ls != 12) begin
            n_fail++;
            $display("FAIL tiny_line_len got %0d want 12", pcnt[1] - last_ls);
          end
        end
        last_ls = pcnt[1];
      end
      if (act[1].fs === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 4) begin
          n_chk++;
          if (act[1].fc !== 16'd0) begin
            n_fail++;
            $display("FAIL tiny_fcnt_wrap got %0d want 0", act[1].fc);
          end
        end
      end
    end
    stb[1] = 1'b0;
    n_chk++;
    if (fs_cnt < 5) begin n_fail++; $display("FAIL tiny_timeout got %0d frames want 5", fs_cnt); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin stb[k] = 1'b0; rst[k] = 1'b1; pcnt[k] = 0; adv[k] = 1'b0; end
    test_reset();
    test_line();
    test_sparse_stb();
    test_frame();
    test_random_stb();
    test_reset_mid();
    test_tiny_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path. It produces horizontal/vertical sync, data-enable, pixel coordinates, line/frame event strobes and a frame counter for any progressive video mode defined by porch/sync/active parameters. It advances only on a pixel-rate strobe, so it can run from a fast system clock. It feeds the pixel/framebuffer logic and the DAC/pin drivers.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active low)
- V_POL, 0, vsync asserted level (0 = active low)
- CW, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FCW, 16, frame counter width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_pix_stb  in  1  pixel-rate enable; the raster advances one position per cycle it is high
- o_hs  out  1  horizontal sync, polarity H_POL
- o_vs  out  1  vertical sync, polarity V_POL
- o_de  out  1  high while the position is in the active area
- o_x  out  CW  horizontal position counter, 0..H_TOTAL-1
- o_y  out  CW  vertical position counter, 0..V_TOTAL-1
- o_line_start  out  1  one i_clk pulse on entering h=0
- o_frame_start  out  1  one i_clk pulse on entering (0,0)
- o_vblank_start  out  1  one i_clk pulse on entering (0,V_ACTIVE); the safe-to-update point
- o_frame_cnt  out  FCW  completed-frame count, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the V_ parameters. Defaults give 800 x 525.
- Line layout, h from 0: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The vertical layout is identical, in lines.
- Counters h, v are registers. On a cycle with i_pix_stb=1:
  - h increments.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 together with h=H_TOTAL-1, v wraps to 0 and o_frame_cnt increments, modulo 2^FCW.
- On a cycle with i_pix_stb=0, all counters and levels hold and all pulses are 0.
- All outputs are registers. Levels are decoded from the next-state counter values, so in every cycle they describe the current (h,v):
  - o_x=h, o_y=v.
  - o_de = (h<H_ACTIVE)&(v<V_ACTIVE).
  - o_hs = H_POL when h is in the sync range, otherwise ~H_POL.
  - o_vs = V_POL when v is in the sync range, otherwise ~V_POL. o_vs changes at h=0 line boundaries.
- Pulses are high for exactly one i_clk cycle: the cycle in which the registered position first equals the event position after a stb-advance. o_frame_start implies o_line_start.
- Reset values:
  - h=0, v=0, o_x=0, o_y=0, o_de=1.
  - o_hs=~H_POL, o_vs=~V_POL.
  - All pulses 0 (no pulse for the reset position), o_frame_cnt=0.
- Reset mid-frame returns to (0,0) on the next edge, with no pulses. i_rst overrides i_pix_stb.

## Timing
- Latency: outputs change on the i_clk edge at which i_pix_stb is sampled high. There is no extra pipeline.
- Back-to-back strobes (i_pix_stb tied high) give one position per i_clk.
- The wrap of h at H_TOTAL-1 and of v at V_TOTAL-1 is exact: a line is H_TOTAL strobes and a frame is H_TOTAL*V_TOTAL strobes.
- o_frame_cnt increments in the same cycle o_frame_start asserts.
- Widths: comparisons are done at CW bits. Parameter sums must not exceed 2^CW-1; this is a static requirement, not checked in RTL.

## Test plan
- Reset, then i_pix_stb high for 800 cycles (defaults):
  - o_x runs 0..799 then returns to 0.
  - o_hs low exactly for x=656..751.
  - o_de low from x=640.
  - o_line_start pulses once, on the cycle o_x returns to 0, with o_y=1.
- Full frame, 420000 strobes:
  - o_vs low for y=490..491 only.
  - o_vblank_start pulses once, at (0,480).
  - o_frame_start at (0,0), with o_frame_cnt=1.
- i_pix_stb asserted every 4th cycle: state advances only on strobe cycles, and pulses last one i_clk cycle, not 4.
- H_POL=1, V_POL=1 with an 8x4-active tiny mode (FP=1, SYNC=2, BP=1): hsync high for x=9..10, and the line length is 12.
- i_rst asserted at (400,300) together with i_pix_stb: next cycle (0,0), o_de=1, no pulses, o_frame_cnt=0.
- FCW=2: after 4 frames o_frame_cnt wraps 3 to 0, coincident with o_frame_start.
